// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared FSM type and parameter defaults
// for the async FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int DEF_D_WIDTH   = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request bundle, FIFO write port
// and grant status seen by the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int D_WIDTH = fifo_wr_arbiter_pkg::DEF_D_WIDTH,
    parameter int NUM_REQ = fifo_wr_arbiter_pkg::DEF_NUM_REQ,
    parameter int GNT_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*D_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       w_full;
    logic                       w_en;
    logic [D_WIDTH-1:0]         w_data;
    logic [GNT_W-1:0]           grant_id;
    logic                       busy;
    logic                       burst_done;

    modport master (
        input  req_valid, req_data, w_full,
        output req_ready, w_en, w_data,
        output grant_id, busy, burst_done
    );

    modport slave (
        output req_valid, req_data, w_full,
        input  req_ready, w_en, w_data,
        input  grant_id, busy, burst_done
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin chooser, first requester
// after last_gnt (wrapping modulo NUM_REQ).
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   last_gnt,
    output logic               any_req,
    output logic [GNT_W-1:0]   next_idx
);

    localparam logic [GNT_W:0] N_EXT = (GNT_W+1)'(NUM_REQ);
    localparam logic [GNT_W-1:0] N_TOP = GNT_W'(NUM_REQ-1);

    logic [GNT_W-1:0]     start;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [GNT_W-1:0]     off;
    logic                 found;
    logic [GNT_W:0]       sum;

    assign any_req = |req;
    assign dbl     = {req, req};

    always_comb begin
        start = (last_gnt == N_TOP) ? '0 : last_gnt + 1'b1;
        rot   = dbl[start +: NUM_REQ];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = GNT_W'(i);
            end
        end
        // explicit wrap keeps non-power-of-2 NUM_REQ in range
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= N_EXT) begin
            next_idx = GNT_W'(sum - N_EXT);
        end else begin
            next_idx = sum[GNT_W-1:0];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter in front of the
// async FIFO write port; zero-latency data mux.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int GNT_W     = $clog2(NUM_REQ),
    parameter int BCNT_W    = $clog2(MAX_BURST+1)
) (
    input logic               w_clk,
    input logic               w_rst,
    fifo_wr_arbiter_if.master bus
);

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST-1);
    localparam logic [GNT_W-1:0]  RST_LAST  = GNT_W'(NUM_REQ-1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [GNT_W-1:0]  grant_q;
    logic [GNT_W-1:0]  grant_nxt;
    logic [GNT_W-1:0]  last_q;
    logic [GNT_W-1:0]  last_nxt;
    logic [GNT_W-1:0]  pick;
    logic [BCNT_W-1:0] beat_q;
    logic [BCNT_W-1:0] beat_nxt;
    logic              done_q;
    logic              done_nxt;
    logic              any_req;
    logic              xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_pick (
        .req      (bus.req_valid),
        .last_gnt (last_q),
        .any_req  (any_req),
        .next_idx (pick)
    );

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_q;
        last_nxt      = last_q;
        beat_nxt      = beat_q;
        done_nxt      = 1'b0;
        xfer          = 1'b0;
        bus.req_ready = '0;
        bus.w_en      = 1'b0;
        bus.w_data    = bus.req_data[grant_q*D_WIDTH +: D_WIDTH];
        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_nxt = pick;
                    last_nxt  = pick;
                    beat_nxt  = '0;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                // reset gates the handshake in the same cycle
                xfer = bus.req_valid[grant_q] & ~bus.w_full & ~w_rst;
                bus.req_ready[grant_q] = ~bus.w_full & ~w_rst;
                bus.w_en = xfer;
                if (xfer) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_nxt  = '0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        beat_nxt = beat_q + 1'b1;
                    end
                end else if (!bus.req_valid[grant_q]) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            last_q  <= RST_LAST;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            beat_q  <= beat_nxt;
            done_q  <= done_nxt;
        end
    end

    assign bus.grant_id   = grant_q;
    assign bus.busy       = (state == ST_BURST);
    assign bus.burst_done = done_q;

endmodule
